lsu_ctrl: RTL and testbench
===========================

Name: lsu_ctrl

Overview:
- Load/store unit sitting between the execute stage and the data-memory port.
- Accepts one load or store per transaction, checks alignment, and converts it into a word-aligned memory request with byte strobes and lane-shifted write data.
- Waits for the memory response, then lane-extracts and sign/zero-extends read data before returning it to writeback.
- All transfers use valid/ready handshakes on both sides; at most one transaction is outstanding.

Parameters:
- XLEN, 32, data and address width (only 32 supported).
- TIMEOUT, 256, cycles to wait for mem_ready or mem_rvalid before aborting with an error; 0 disables the timeout.

Ports:
- clk  in  1  single clock; all state updates on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  execute stage presents an access.
- req_ready  out  1  unit can accept a request.
- req_addr  in  32  byte address.
- req_wen  in  1  1 = store, 0 = load.
- req_op  in  3  MemOp: 000 b(signed), 001 h(signed), 010 w, 100 bu, 101 hu.
- req_wdata  in  32  store data, right-aligned.
- resp_valid  out  1  result available.
- resp_ready  in  1  writeback accepts the result.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- resp_err  out  1  misaligned, illegal op, or timeout.
- mem_valid  out  1  memory request valid.
- mem_ready  in  1  memory accepts the request.
- mem_addr  out  32  {req_addr[31:2], 2'b00}.
- mem_wen  out  1  store request.
- mem_wmask  out  4  byte strobes.
- mem_wdata  out  32  lane-shifted store data.
- mem_rvalid  in  1  read data valid (one-cycle pulse).
- mem_rdata  in  32  aligned word read.

Behaviour:
- Reset (asynchronous, any state): state returns to IDLE.
  - req_ready=1 after reset; all other outputs 0.
  - Captured registers and the timeout counter clear.
- Byte order is little-endian; lane = addr[1:0].
- Store:
  - mem_wdata = wdata << 8*lane.
  - mem_wmask = 0001 (b), 0011 (h), 1111 (w), each << lane.
- Load:
  - Extract byte/half at lane from mem_rdata.
  - Sign-extend for 000/001, zero-extend for 100/101; 010 passes the word through.
- Error checks, evaluated at accept:
  - h with addr[0]=1, or w with addr[1:0]!=0 → misaligned.
  - Store with op not in {000,001,010}, or any op in {011,110,111} → illegal.
  - Errored requests never reach memory.
- FSM states:
  - IDLE: req_ready=1. On req_valid, capture all request fields. Go to RESP with err=1 if the checks fail, else go to ISSUE.
  - ISSUE: mem_valid=1; mem_* are driven from captured registers and held stable until mem_ready.
    - On mem_ready, a store goes to RESP; a load goes to RDWAIT.
  - RDWAIT: on mem_rvalid, capture the extended data and go to RESP.
  - RESP: resp_valid=1; resp_rdata/resp_err held stable until resp_ready, then go to IDLE.
- req_ready is 1 only in IDLE; there is no same-cycle back-to-back accept from RESP.
- Timeout:
  - Counter increments each cycle in ISSUE/RDWAIT and clears on state entry.
  - Reaching TIMEOUT-1 without the awaited event drops mem_valid and goes to RESP with err=1.
  - A mem_ready or mem_rvalid arriving in the same cycle as expiry wins.
- mem_rvalid outside RDWAIT is ignored; this covers late responses after a timeout or reset.
- Latency, measured from the accept edge (cycle 0):
  - Errored request: resp_valid at cycle 1.
  - Store with mem_ready=1: mem_valid at 1, resp_valid at 2.
  - Load with mem_ready=1 and mem_rvalid the next cycle: resp_valid at 3.
  - Each memory stall cycle adds one.

Decomposition:
- lsu_pkg:
  - MemOp localparams (OP_B, OP_H, OP_W, OP_BU, OP_HU).
  - State enum (IDLE, ISSUE, RDWAIT, RESP).
  - Mask base constants.
- Sub-module lsu_align: purely combinational store shift/mask generation and load extract/extend, parameterless. The FSM, counter and registers stay in lsu_ctrl.

Test Plan:
- Store byte: addr=0x80000003, op=000, wdata=0x000000AB, mem_ready=1 → mem_addr=0x80000000, mem_wmask=1000, mem_wdata=0xAB000000; resp_valid at cycle 2, err=0.
- Signed and unsigned halfword load: addr=0x80000002, mem_rdata=0x8001xxxx.
  - op=001 → resp_rdata=0xFFFF8001.
  - op=101 → resp_rdata=0x00008001.
- Misaligned word: store to addr=0x80000001, op=010 → mem_valid never asserts; resp_valid at cycle 1, resp_err=1.
- Backpressure: mem_ready held 0 for 5 cycles, then mem_rvalid; resp_ready held 0 for 3 cycles.
  - mem_* stable throughout the mem_ready stall.
  - resp_rdata stable throughout the resp_ready stall.
  - req_ready stays 0 until resp accepted.
- Timeout and reset: with TIMEOUT=8 and mem_rvalid never returned, resp_err=1 at the expected cycle and a later mem_rvalid is ignored. Asserting rst_n=0 mid-RDWAIT drops all outputs immediately and returns req_ready=1.

Source files
------------

// File: rtl/lsu_pkg.sv
// Load/store unit shared definitions: memory-op encodings, FSM states, strobe bases.
// Pure declarations and decode helpers; no timing or flow-control behaviour of its own.
package lsu_pkg;

  localparam int XLEN_SUPPORTED = 32;

  localparam logic [2:0] OP_B  = 3'b000;
  localparam logic [2:0] OP_H  = 3'b001;
  localparam logic [2:0] OP_W  = 3'b010;
  localparam logic [2:0] OP_BU = 3'b100;
  localparam logic [2:0] OP_HU = 3'b101;

  localparam logic [3:0] MASK_B = 4'b0001;
  localparam logic [3:0] MASK_H = 4'b0011;
  localparam logic [3:0] MASK_W = 4'b1111;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RDWAIT,
    RESP
  } lsu_state_e;

  typedef struct packed {
    logic [31:0] addr;
    logic        wen;
    logic [2:0]  op;
    logic [31:0] wdata;
  } lsu_req_t;

  // Unsigned loads have no store counterpart, so they are only legal with wen=0.
  function automatic logic op_illegal(input logic wen, input logic [2:0] op);
    logic bad;
    bad = 1'b1;
    case (op)
      OP_B, OP_H, OP_W: bad = 1'b0;
      OP_BU, OP_HU:     bad = wen;
      default:          bad = 1'b1;
    endcase
    return bad;
  endfunction

  function automatic logic misaligned(input logic [2:0] op, input logic [1:0] lane);
    logic bad;
    bad = 1'b0;
    case (op)
      OP_H, OP_HU: bad = lane[0];
      OP_W:        bad = (lane != 2'b00);
      default:     bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane steering for the LSU: store shift/strobes and load extract/extend.
// Purely combinational (zero latency); no handshakes, so no backpressure of its own.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [1:0]  lane,
  input  logic [31:0] st_data,
  input  logic [31:0] ld_word,
  output logic [3:0]  st_mask,
  output logic [31:0] st_wdata,
  output logic [31:0] ld_data
);

  logic [4:0]  shamt;
  logic [3:0]  mask_base;
  logic [31:0] ld_shifted;

  assign shamt = {lane, 3'b000};

  always_comb begin
    mask_base = MASK_W;
    case (op[1:0])
      2'b00:   mask_base = MASK_B;
      2'b01:   mask_base = MASK_H;
      default: mask_base = MASK_W;
    endcase
    st_mask  = mask_base << lane;
    st_wdata = st_data << shamt;
  end

  // Bring the addressed lane down to bit 0 before extending.
  always_comb begin
    ld_shifted = ld_word >> shamt;
    ld_data    = ld_word;
    case (op)
      OP_B:    ld_data = {{24{ld_shifted[7]}}, ld_shifted[7:0]};
      OP_H:    ld_data = {{16{ld_shifted[15]}}, ld_shifted[15:0]};
      OP_BU:   ld_data = {24'h000000, ld_shifted[7:0]};
      OP_HU:   ld_data = {16'h0000, ld_shifted[15:0]};
      default: ld_data = ld_word;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store unit: one outstanding access; errored req -> resp in 1 cycle, store 2, load 3 (+stalls).
// req_ready only in IDLE; mem_* and resp_* are held stable until their ready, with optional timeout.
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 256
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [XLEN-1:0] req_addr,
  input  logic            req_wen,
  input  logic [2:0]      req_op,
  input  logic [XLEN-1:0] req_wdata,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_rdata,
  output logic            resp_err,
  output logic            mem_valid,
  input  logic            mem_ready,
  output logic [XLEN-1:0] mem_addr,
  output logic            mem_wen,
  output logic [3:0]      mem_wmask,
  output logic [XLEN-1:0] mem_wdata,
  input  logic            mem_rvalid,
  input  logic [XLEN-1:0] mem_rdata
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  lsu_state_e        state_q, state_d;
  lsu_req_t          req_q, req_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              req_bad;
  logic              expired;
  logic [3:0]        st_mask;
  logic [31:0]       st_wdata;
  logic [31:0]       ld_data;

  lsu_align u_align (
    .op       (req_q.op),
    .lane     (req_q.addr[1:0]),
    .st_data  (req_q.wdata),
    .ld_word  (mem_rdata),
    .st_mask  (st_mask),
    .st_wdata (st_wdata),
    .ld_data  (ld_data)
  );

  assign req_bad = op_illegal(req_wen, req_op) | misaligned(req_op, req_addr[1:0]);
  assign expired = (TIMEOUT != 0) && (cnt_q == CNT_LAST);

  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    cnt_d      = '0;
    req_ready  = 1'b0;
    mem_valid  = 1'b0;
    resp_valid = 1'b0;

    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          req_d   = '{addr: req_addr, wen: req_wen, op: req_op, wdata: req_wdata};
          rdata_d = '0;
          err_d   = req_bad;
          state_d = req_bad ? RESP : ISSUE;
        end
      end

      ISSUE: begin
        mem_valid = 1'b1;
        // An acceptance in the expiry cycle still completes normally.
        if (mem_ready) begin
          state_d = req_q.wen ? RESP : RDWAIT;
        end else if (expired) begin
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      RDWAIT: begin
        if (mem_rvalid) begin
          rdata_d = ld_data;
          state_d = RESP;
        end else if (expired) begin
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      req_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  // Memory and response buses read as zero outside the states that own them.
  assign mem_addr   = mem_valid ? {req_q.addr[31:2], 2'b00} : '0;
  assign mem_wen    = mem_valid & req_q.wen;
  assign mem_wmask  = mem_valid ? st_mask : 4'b0000;
  assign mem_wdata  = mem_valid ? st_wdata : '0;
  assign resp_rdata = resp_valid ? rdata_q : '0;
  assign resp_err   = resp_valid & err_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed and random bench for lsu_ctrl with a response scoreboard and latency checks.
module tb_lsu_ctrl;

  logic        clk;
  logic        rst_n;
  logic        req_valid, req_ready, req_wen;
  logic [31:0] req_addr, req_wdata;
  logic [2:0]  req_op;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_rdata;
  logic        mem_valid, mem_ready, mem_wen, mem_rvalid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wmask;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t sb_q[$];
  int   tests = 0;
  int   fails = 0;

  lsu_ctrl #(.XLEN(32), .TIMEOUT(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .req_wen    (req_wen),
    .req_op     (req_op),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_valid  (mem_valid),
    .mem_ready  (mem_ready),
    .mem_addr   (mem_addr),
    .mem_wen    (mem_wen),
    .mem_wmask  (mem_wmask),
    .mem_wdata  (mem_wdata),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    tests++;
    assert (obs === want) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, want);
    end
  endtask

  function automatic logic m_err(input logic [31:0] a, input logic w, input logic [2:0] op);
    logic legal, algn;
    legal = (op == 3'd0) || (op == 3'd1) || (op == 3'd2) || (!w && (op == 3'd4 || op == 3'd5));
    if (op[1:0] == 2'd1)      algn = (a[0] == 1'b0);
    else if (op[1:0] == 2'd2) algn = (a[1:0] == 2'd0);
    else                      algn = 1'b1;
    return !(legal && algn);
  endfunction

  function automatic logic [3:0] m_mask(input logic [2:0] op, input logic [1:0] lane);
    logic [3:0] m;
    int n, ln;
    n  = 1 << int'(op[1:0]);
    ln = int'(lane);
    m  = '0;
    for (int i = 0; i < 4; i++) m[i] = (i >= ln) && (i < ln + n);
    return m;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [31:0] wd, input logic [1:0] lane);
    logic [31:0] r;
    int ln;
    ln = int'(lane);
    r  = '0;
    for (int i = 0; i < 4; i++) if (i >= ln) r[8*i +: 8] = wd[8*(i-ln) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] op, input logic [1:0] lane, input logic [31:0] word);
    logic [31:0] v;
    v = word >> (8 * int'(lane));
    case (op)
      3'd0:    return 32'($signed(v[7:0]));
      3'd1:    return 32'($signed(v[15:0]));
      3'd4:    return 32'(v[7:0]);
      3'd5:    return 32'(v[15:0]);
      default: return word;
    endcase
  endfunction

  // mstall<0: memory never accepts; rvdly<0: read data never returns; to_lat>0: expected timeout latency.
  task automatic run_txn(input string tag, input logic [31:0] addr, input logic wen, input logic [2:0] op,
                         input logic [31:0] wd, input logic [31:0] word, input int mstall, input int rvdly,
                         input int rstall, input int to_lat);
    exp_t        e;
    logic        bad;
    logic [31:0] ea, ed;
    logic [3:0]  em;
    int          lat, exp_lat;
    bad     = m_err(addr, wen, op);
    e.err   = bad | (to_lat > 0);
    e.rdata = (e.err || wen) ? 32'h0 : m_load(op, addr[1:0], word);
    sb_q.push_back(e);
    ea = {addr[31:2], 2'b00};
    em = m_mask(op, addr[1:0]);
    ed = m_wdata(wd, addr[1:0]);
    if (to_lat > 0)  exp_lat = to_lat;
    else if (bad)    exp_lat = 1;
    else if (wen)    exp_lat = 2 + mstall;
    else             exp_lat = 3 + mstall + rvdly;

    chk({tag, " req_ready idle"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_addr = addr; req_wen = wen; req_op = op; req_wdata = wd;
    mem_ready = 1'b0; mem_rvalid = 1'b0; resp_ready = 1'b0;
    tick();
    req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom; req_op = 3'($urandom_range(0, 7));
    lat = 1;

    if (bad) chk({tag, " no mem_valid"}, 32'(mem_valid), 32'd0);
    if (!bad) begin
      for (int i = 0; i <= mstall; i++) begin
        chk({tag, " mem_valid"}, 32'(mem_valid), 32'd1);
        chk({tag, " mem_addr"}, mem_addr, ea);
        chk({tag, " mem_wen"}, 32'(mem_wen), 32'(wen));
        if (wen) begin
          chk({tag, " mem_wmask"}, 32'(mem_wmask), 32'(em));
          chk({tag, " mem_wdata"}, mem_wdata, ed);
        end
        chk({tag, " req_ready busy"}, 32'(req_ready), 32'd0);
        chk({tag, " resp_valid early"}, 32'(resp_valid), 32'd0);
        mem_ready = (i == mstall);
        tick();
        lat++;
      end
      mem_ready = 1'b0;
      if (!wen && mstall >= 0 && rvdly >= 0) begin
        for (int i = 0; i < rvdly; i++) begin
          chk({tag, " mem_valid rdwait"}, 32'(mem_valid), 32'd0);
          chk({tag, " resp_valid rdwait"}, 32'(resp_valid), 32'd0);
          tick();
          lat++;
        end
        mem_rvalid = 1'b1;
        mem_rdata  = word;
        tick();
        lat++;
        mem_rvalid = 1'b0;
        mem_rdata  = $urandom;
      end
    end

    while (!resp_valid && lat < 300) begin
      tick();
      lat++;
    end
    chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, " mem_valid in resp"}, 32'(mem_valid), 32'd0);
    e = sb_q.pop_front();
    // Junk read data in RESP and the following IDLE cycle must be ignored.
    for (int i = 0; i <= rstall; i++) begin
      chk({tag, " resp_valid"}, 32'(resp_valid), 32'd1);
      chk({tag, " resp_rdata"}, resp_rdata, e.rdata);
      chk({tag, " resp_err"}, 32'(resp_err), 32'(e.err));
      chk({tag, " req_ready in resp"}, 32'(req_ready), 32'd0);
      mem_rvalid = 1'b1;
      mem_rdata  = $urandom;
      resp_ready = (i == rstall);
      tick();
    end
    resp_ready = 1'b0;
    chk({tag, " resp_valid after accept"}, 32'(resp_valid), 32'd0);
    chk({tag, " req_ready after accept"}, 32'(req_ready), 32'd1);
    tick();
    mem_rvalid = 1'b0;
    chk({tag, " late rvalid ignored"}, 32'(resp_valid), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_addr = '0; req_wen = 1'b0; req_op = '0; req_wdata = '0;
    resp_ready = 1'b0; mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset req_ready", 32'(req_ready), 32'd1);
    chk("reset mem_valid", 32'(mem_valid), 32'd0);
    chk("reset resp_valid", 32'(resp_valid), 32'd0);
    chk("reset resp_rdata", resp_rdata, 32'd0);
    chk("reset resp_err", 32'(resp_err), 32'd0);
    chk("reset mem_addr", mem_addr, 32'd0);
    chk("reset mem_wmask", 32'(mem_wmask), 32'd0);
    chk("reset mem_wdata", mem_wdata, 32'd0);
    chk("reset mem_wen", 32'(mem_wen), 32'd0);
    rst_n = 1'b1;
    tick();

    run_txn("sb_lane3",  32'h8000_0003, 1'b1, 3'b000, 32'h0000_00AB, 32'h0, 0, 0, 0, 0);
    run_txn("lh_signed", 32'h8000_0002, 1'b0, 3'b001, 32'h0, 32'h8001_5A5A, 0, 0, 0, 0);
    run_txn("lhu",       32'h8000_0002, 1'b0, 3'b101, 32'h0, 32'h8001_5A5A, 0, 0, 0, 0);
    run_txn("sw_misal",  32'h8000_0001, 1'b1, 3'b010, 32'hDEAD_BEEF, 32'h0, 0, 0, 0, 0);
    run_txn("lw_stall",  32'h8000_0010, 1'b0, 3'b010, 32'h0, 32'h1234_5678, 5, 0, 3, 0);
    run_txn("sh_lane2",  32'h0000_0102, 1'b1, 3'b001, 32'hCAFE_F00D, 32'h0, 2, 0, 1, 0);
    run_txn("lb_lane1",  32'h0000_0041, 1'b0, 3'b000, 32'h0, 32'h0000_9C00, 0, 1, 0, 0);
    run_txn("lbu_lane1", 32'h0000_0041, 1'b0, 3'b100, 32'h0, 32'h0000_9C00, 0, 0, 0, 0);
    run_txn("st_op_bu",  32'h0000_0040, 1'b1, 3'b100, 32'h11, 32'h0, 0, 0, 0, 0);
    run_txn("ld_op_011", 32'h0000_0040, 1'b0, 3'b011, 32'h0, 32'h0, 0, 0, 0, 0);
    run_txn("lh_misal",  32'h0000_0043, 1'b0, 3'b001, 32'h0, 32'h0, 0, 0, 0, 0);
    run_txn("sw_ready_at_expiry", 32'h0000_0080, 1'b1, 3'b010, 32'h0BAD_CAFE, 32'h0, 7, 0, 0, 0);
    run_txn("lw_rvalid_at_expiry", 32'h0000_0084, 1'b0, 3'b010, 32'h0, 32'hA5A5_0F0F, 0, 7, 0, 0);
    run_txn("sw_timeout", 32'h0000_0088, 1'b1, 3'b010, 32'h1, 32'h0, -1, 0, 1, 9);
    run_txn("lw_timeout", 32'h0000_008C, 1'b0, 3'b010, 32'h0, 32'h0, 0, -1, 1, 10);

    // Asynchronous reset while waiting for read data.
    req_valid = 1'b1; req_addr = 32'h8000_0004; req_wen = 1'b0; req_op = 3'b010; mem_ready = 1'b1;
    tick();
    req_valid = 1'b0;
    tick();
    mem_ready = 1'b0;
    chk("rst_mid pre req_ready", 32'(req_ready), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid req_ready", 32'(req_ready), 32'd1);
    chk("rst_mid mem_valid", 32'(mem_valid), 32'd0);
    chk("rst_mid resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_mid mem_addr", mem_addr, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    mem_rvalid = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    tick();
    mem_rvalid = 1'b0;
    chk("rst_mid late rvalid", 32'(resp_valid), 32'd0);
    chk("rst_mid idle", 32'(req_ready), 32'd1);
    run_txn("after_reset", 32'h8000_0000, 1'b0, 3'b010, 32'h0, 32'h7654_3210, 0, 0, 0, 0);

    for (int n = 0; n < 24; n++) begin
      run_txn("rand", $urandom, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom, $urandom,
              $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 1), 0);
    end

    chk("scoreboard drained", 32'(sb_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
